// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: valid/ready word output bundle of the serial frame receiver
interface serial_frame_rx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic parity_err;
  logic frame_err;
  logic overrun;
  modport master(output dout, dout_valid, parity_err, frame_err, overrun, input dout_ready);
  modport slave(input dout, dout_valid, parity_err, frame_err, overrun, output dout_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampled serial frame receiver with parity/stop checks and a one-entry output buffer
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  serial_frame_rx_if.master bus
);
  localparam int HALF = OVERSAMPLE / 2;
  localparam int CW   = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW   = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, dout_q, dout_d;
  logic par_q, par_d, valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;
  logic din_s, last, complete, take;
  assign din_s = sync_q[1];
  assign last = cnt_q == CW'(OVERSAMPLE - 1);
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        par_d = 1'b0;
        state_d = din_s ? IDLE : START;
      end
      START: if (cnt_q == CW'(HALF - 1)) state_d = din_s ? IDLE : DATA;
      DATA: if (last) begin
        shift_d = {din_s, shift_q[DATA_W-1:1]};
        par_d   = par_q ^ din_s;
        bit_d   = bit_q + BW'(1);
        if (bit_q == BW'(DATA_W - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (last) begin
        par_d   = par_q ^ din_s;
        state_d = STOP;
      end
      STOP: if (last) begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end
  // a completed frame is accepted only if the buffer is empty or draining this cycle
  always_comb begin
    take    = complete && (!valid_q || bus.dout_ready);
    valid_d = take ? 1'b1 : (valid_q && !bus.dout_ready);
    dout_d  = take ? shift_q : dout_q;
    pe_d    = take ? ((PARITY_EN != 0) && par_q) : pe_q;
    fe_d    = take ? !din_s : fe_q;
    ovr_d   = ovr_q || (complete && !take);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], din};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.overrun    = ovr_q;
endmodule
